// File: rtl/ab_stim_chk.sv
// Stimulus source and response checker for the strobe-sampled AND path.
// LFSR-driven a/b go out at the strobe rate; returned c is checked mid-period against delayed a&b.
module ab_stim_chk #(
  parameter int          TICK_DIV = 4,
  parameter int          TICK_GRP = 16,
  parameter int          LAT      = 1,
  parameter int          NUM_VEC  = 64,
  parameter int          CNT_W    = 8,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pi_c,
  output logic             po_a,
  output logic             po_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int C1W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int C2W = $clog2(TICK_GRP);

  localparam logic [C1W-1:0]   CNT1_MAX = C1W'(TICK_DIV - 1);
  localparam logic [C2W-1:0]   CNT2_MAX = C2W'(TICK_GRP - 1);
  localparam logic [C2W-1:0]   CNT2_MID = C2W'(TICK_GRP / 2 - 1);
  localparam logic [1:0]       SKIP_LAT = 2'(LAT);
  localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [C1W-1:0] cnt1;
  logic [C2W-1:0] cnt2;
  logic           tick;
  logic           strobe;
  logic           chk;

  logic [7:0]     lfsr;
  logic [7:0]     lfsr_nxt;
  logic [3:1]     hist;
  logic           hist0;
  logic [3:0]     hist_all;
  logic [1:0]     skip;

  logic           start_run;
  logic           in_skip;
  logic           do_cmp;
  logic           last_cmp;
  logic           mis;

  assign start_run = (state == IDLE) && start;
  assign tick      = (state == RUN) && (cnt1 == CNT1_MAX);
  assign strobe    = tick && (cnt2 == CNT2_MAX);
  assign chk       = tick && (cnt2 == CNT2_MID);

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  assign hist0     = po_a & po_b;
  assign hist_all  = {hist, hist0};
  assign mis       = (pi_c != hist_all[LAT]);

  // The skip counter saturates at LAT, so the first LAT checks only prime the pipe.
  assign in_skip   = (skip != SKIP_LAT);
  assign do_cmp    = chk && !in_skip;
  assign last_cmp  = do_cmp && (vec_cnt == VEC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_cmp) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || (state != RUN)) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (tick) begin
        cnt1 <= '0;
        if (cnt2 == CNT2_MAX) begin
          cnt2 <= '0;
        end else begin
          cnt2 <= cnt2 + 1'b1;
        end
      end else begin
        cnt1 <= cnt1 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= SEED;
      po_a    <= 1'b0;
      po_b    <= 1'b0;
      hist    <= '0;
      skip    <= '0;
      vec_cnt <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else if (start_run) begin
      lfsr    <= SEED;
      po_a    <= SEED[0];
      po_b    <= SEED[1];
      hist    <= '0;
      skip    <= '0;
      vec_cnt <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else if (state == RUN) begin
      // hist captures a&b before the registered outputs move to the next vector.
      if (strobe) begin
        lfsr <= lfsr_nxt;
        po_a <= lfsr_nxt[0];
        po_b <= lfsr_nxt[1];
        hist <= {hist[2:1], hist0};
      end
      if (chk) begin
        if (in_skip) begin
          skip <= skip + 1'b1;
        end else begin
          vec_cnt <= vec_cnt + 1'b1;
          if (mis) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
      end
      if (last_cmp) begin
        pass <= (err_cnt == '0) && !mis;
      end
    end
  end

endmodule
